// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller: PC sequencer for a combinational imem with a registered decode slot, j/jal predecode and self-jump halt
module imem_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Resume,
  output logic        Halted,
  output logic [31:0] FetchCount
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state, state_d;
  logic [31:0] pc, pc4, jump_pc, next_pc;
  logic is_jump, self_jump, capture, redir;
  assign ImemAddress = pc;
  assign pc4 = pc + 32'd4;
  assign jump_pc = {pc4[31:28], ImemInstruction[25:0], 2'b00};
  assign is_jump = ImemInstruction[31:27] == 5'b00001;
  assign next_pc = is_jump ? jump_pc : pc4;
  // only plain j to its own address is an idle loop; jal to self keeps fetching
  assign self_jump = ImemInstruction[31:26] == 6'h02 && jump_pc == pc;
  assign redir = Redirect && state != IDLE;
  assign capture = state == FETCH && !redir && (!InstrValid || InstrReady);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = (state == IDLE || redir) ? FETCH :
              state == HALT ? (Resume ? FETCH : HALT) :
              (capture && self_jump) ? HALT : FETCH;
  always_comb Halted = state == HALT;
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC & ~32'd3;
      InstrOut <= '0;
      PCOut <= '0;
      InstrValid <= 1'b0;
      FetchCount <= '0;
    end else begin
      if (redir) pc <= RedirectTarget & ~32'd3;
      else if (state == HALT && Resume) pc <= pc4;
      else if (capture) pc <= next_pc;
      if (capture) begin
        InstrOut <= ImemInstruction;
        PCOut <= pc;
      end
      InstrValid <= redir ? 1'b0 : capture ? 1'b1 : InstrValid && !InstrReady;
      FetchCount <= FetchCount + 32'(InstrValid && InstrReady);
    end
endmodule

// File: tb/tb_imem_fetch_controller.sv
// tb_imem_fetch_controller: directed checks of fetch sequencing, stall, redirect, halt/resume and reset
module tb_imem_fetch_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] ImemAddress, ImemInstruction, InstrOut, PCOut, FetchCount;
  logic [31:0] RedirectTarget = '0;
  logic InstrValid, Halted;
  logic InstrReady = 1'b1;
  logic Redirect = 1'b0;
  logic Resume = 1'b0;
  logic [31:0] mem [64];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] cnt;

  always #5 clk = ~clk;

  assign ImemInstruction = mem[ImemAddress[7:2]];

  imem_fetch_controller #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset(reset), .ImemAddress(ImemAddress), .ImemInstruction(ImemInstruction),
    .InstrOut(InstrOut), .PCOut(PCOut), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .Resume(Resume),
    .Halted(Halted), .FetchCount(FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h20000000 + 32'(i);
    mem[0]  = 32'h20042f5b;
    mem[11] = 32'h0800000b;
    mem[20] = 32'h08000018;
    mem[24] = 32'h0c000018;
    tick();
    tick();
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_count", FetchCount, 32'd0);
    chk("rst_addr", ImemAddress, 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_instr", InstrOut, 32'd0);
    chk("rst_pcout", PCOut, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_valid", 32'(InstrValid), 32'd0);
    tick();
    chk("first_valid", 32'(InstrValid), 32'd1);
    chk("first_instr", InstrOut, 32'h20042f5b);
    chk("first_pcout", PCOut, 32'd0);
    for (int k = 1; k < 12; k++) begin
      tick();
      chk($sformatf("seq_pcout_%0d", k), PCOut, 32'(4 * k));
    end
    chk("halt_instr", InstrOut, 32'h0800000b);
    chk("halt_halted", 32'(Halted), 32'd1);
    chk("halt_addr", ImemAddress, 32'h2c);
    chk("halt_valid", 32'(InstrValid), 32'd1);
    tick();
    chk("halt_drain_valid", 32'(InstrValid), 32'd0);
    chk("halt_count", FetchCount, 32'd12);
    tick();
    chk("halt_stay_valid", 32'(InstrValid), 32'd0);
    chk("halt_stay_addr", ImemAddress, 32'h2c);
    chk("halt_stay_count", FetchCount, 32'd12);
    Resume = 1'b1;
    tick();
    Resume = 1'b0;
    chk("resume_halted", 32'(Halted), 32'd0);
    chk("resume_addr", ImemAddress, 32'h30);
    tick();
    chk("resume_pcout", PCOut, 32'h30);
    chk("resume_valid", 32'(InstrValid), 32'd1);
    Redirect = 1'b1;
    RedirectTarget = 32'h2c;
    tick();
    Redirect = 1'b0;
    chk("redir_count", FetchCount, 32'd13);
    chk("redir_bubble", 32'(InstrValid), 32'd0);
    tick();
    chk("rehalt_pcout", PCOut, 32'h2c);
    chk("rehalt_halted", 32'(Halted), 32'd1);
    tick();
    chk("rehalt_count", FetchCount, 32'd14);
    Resume = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 32'h40;
    tick();
    Resume = 1'b0;
    Redirect = 1'b0;
    chk("both_halted", 32'(Halted), 32'd0);
    chk("both_addr", ImemAddress, 32'h40);
    chk("both_valid", 32'(InstrValid), 32'd0);
    tick();
    chk("both_pcout", PCOut, 32'h40);
    Redirect = 1'b1;
    RedirectTarget = 32'h19;
    tick();
    Redirect = 1'b0;
    chk("r19_addr", ImemAddress, 32'h18);
    chk("r19_valid", 32'(InstrValid), 32'd0);
    tick();
    chk("r19_pcout", PCOut, 32'h18);
    chk("r19_instr", InstrOut, 32'h20000006);
    Redirect = 1'b1;
    RedirectTarget = 32'h50;
    tick();
    Redirect = 1'b0;
    tick();
    chk("j_pcout", PCOut, 32'h50);
    tick();
    chk("j_target_pcout", PCOut, 32'h60);
    chk("j_target_valid", 32'(InstrValid), 32'd1);
    tick();
    chk("jal_self_pcout", PCOut, 32'h60);
    chk("jal_self_halted", 32'(Halted), 32'd0);
    Redirect = 1'b1;
    RedirectTarget = 32'h8;
    tick();
    Redirect = 1'b0;
    tick();
    chk("stall_pcout0", PCOut, 32'h8);
    InstrReady = 1'b0;
    cnt = FetchCount;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_pcout_%0d", k), PCOut, 32'h8);
      chk($sformatf("stall_instr_%0d", k), InstrOut, 32'h20000002);
      chk($sformatf("stall_addr_%0d", k), ImemAddress, 32'hc);
      chk($sformatf("stall_count_%0d", k), FetchCount, cnt);
    end
    InstrReady = 1'b1;
    tick();
    chk("unstall_pcout", PCOut, 32'hc);
    chk("unstall_count", FetchCount, cnt + 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("pre_rst_count", FetchCount, 32'd5);
    chk("pre_rst_valid", 32'(InstrValid), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(InstrValid), 32'd0);
    chk("mid_rst_count", FetchCount, 32'd0);
    chk("mid_rst_addr", ImemAddress, 32'd0);
    chk("mid_rst_halted", 32'(Halted), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
